// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start qualification, mid-bit sampling, SIPO shift strobes, stop check.
// Optional parity bit support when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD   = 1'b0
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic shift_data,
    output logic shift_en,
    output logic busy,
    output logic rx_done,
`ifdef UART_RX_PARITY_EN
    output logic parity_err,
`endif
    output logic frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       sync_q;
    logic             shift_data_q, shift_data_d;
    logic             shift_en_q, shift_en_d;
    logic             busy_q;
    logic             rx_done_q, rx_done_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_s;
`ifdef UART_RX_PARITY_EN
    logic             par_acc_q, par_acc_d;
    logic             par_bad_q, par_bad_d;
    logic             parity_err_q, parity_err_d;
`endif

    assign rx_s = sync_q[1];

    // Next-state and registered-output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shift_data_d = shift_data_q;
        shift_en_d   = 1'b0;
        rx_done_d    = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_acc_d    = par_acc_q;
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
`ifdef UART_RX_PARITY_EN
                par_acc_d = 1'b0;
                par_bad_d = 1'b0;
`endif
                if (cnt_q == HALF_LAST) begin
                    idx_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d        = '0;
                    shift_data_d = rx_s;
                    shift_en_d   = 1'b1;
                    idx_d        = idx_q + IDX_W'(1);
`ifdef UART_RX_PARITY_EN
                    par_acc_d    = par_acc_q ^ rx_s;
                    if (idx_q == IDX_LAST) state_d = ST_PARITY;
`else
                    if (idx_q == IDX_LAST) state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    par_bad_d = ((par_acc_q ^ rx_s) != PARITY_ODD);
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                    parity_err_d = par_bad_q;
`endif
                    if (rx_s) begin
                        rx_done_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Baud counter restarts on every state change and rests at 0 while idle
        if (state_d != state_q || state_q == ST_IDLE || state_q == ST_BREAK) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            sync_q       <= 2'b11;
            shift_data_q <= 1'b0;
            shift_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sync_q       <= {sync_q[0], rx};
            shift_data_q <= shift_data_d;
            shift_en_q   <= shift_en_d;
            busy_q       <= (state_d != ST_IDLE);
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_acc_q    <= par_acc_d;
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign shift_data = shift_data_q;
    assign shift_en   = shift_en_q;
    assign busy       = busy_q;
    assign rx_done    = rx_done_q;
    assign frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART. Synchronises the serial line, detects and qualifies the start bit, and times mid-bit sampling. Drives the 8-bit serial-in/parallel-out shift register with one shift_en pulse and one data bit per received data bit. Checks the stop bit and flags completion or a framing error to the host side.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit period; must be an even number ≥ 4.
DATA_BITS, 8, data bits per frame; fixed to 8 to match the 8-stage SIPO.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  asynchronous reset, active-high
rx  input  1  raw serial line; idles high
shift_data  output  1  sampled data bit, to the SIPO data_in
shift_en  output  1  one-cycle shift strobe, to the SIPO shift_en
busy  output  1  high whenever state is not IDLE
rx_done  output  1  one-cycle pulse when a frame ends with a valid stop bit
frame_err  output  1  one-cycle pulse when the stop bit is sampled low

Behaviour:
- Reset (async, immediate): state=IDLE, baud counter=0, bit_idx=0, 2-flop synchroniser preset to 1. All outputs 0.
- rx passes through a 2-flop synchroniser. rx_s is the synchroniser output. All decisions use rx_s, so line-to-decision latency is 2 cycles.
- All outputs are registered. shift_en is high for exactly one clk cycle. shift_data is valid in the same cycle and is held until the next sample.
- Baud counter counts 0..N-1 in the current state and clears on every state transition.
- IDLE: when rx_s=0, go to START.
- START: wait CLKS_PER_BIT/2 cycles (mid start bit), then sample rx_s.
  - rx_s=0: go to DATA with bit_idx=0.
  - rx_s=1: false start; go to IDLE with no outputs.
- DATA: every CLKS_PER_BIT cycles (mid data bit), drive shift_data=rx_s and pulse shift_en, then increment bit_idx.
  - After the pulse with bit_idx=7, go to STOP.
  - Bits arrive LSB first. After 8 pulses the SIPO's last stage holds bit0 and its first stage holds bit7.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - rx_s=1: pulse rx_done and go to IDLE.
  - rx_s=0: pulse frame_err and go to BREAK.
- BREAK: stay until rx_s=1, then go to IDLE. No outputs.
- Exactly 8 shift_en pulses per frame that reaches STOP. Zero pulses on a false start.
- rx_done and frame_err are mutually exclusive and never coincide with shift_en.
- Back-to-back frames: a new start edge seen in IDLE in the cycle after rx_done is accepted.
- Reset mid-frame: aborts immediately. No partial rx_done or frame_err. The SIPO contents are don't-care.
- shift_en is used as a clock gate downstream, so it must come straight from a flop with no combinational path.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, one bit period long.
  - Adds a PARITY_ODD parameter (default 0 = even parity).
  - Adds output parity_err (1 bit, reset 0).
  - At mid parity bit, the XOR of the 8 sampled bits and rx_s is compared against the expected parity.
  - A mismatch is latched and reported as a one-cycle parity_err pulse at the same cycle as rx_done or frame_err.
  - No shift_en pulse is issued for the parity bit.
- Undefined: no PARITY state, no parity_err port, and the frame is 10 bits.

Test Plan:
1. Reset: assert rst mid-frame at an arbitrary cycle -> all outputs 0 and busy=0 within the same cycle; the next frame is received correctly.
2. Nominal, CLKS_PER_BIT=4: send 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) -> 8 shift_en pulses 4 cycles apart, shift_data sequence 1,0,1,0,0,1,0,1, rx_done pulse 4 cycles after the 8th pulse, SIPO reads 0xA5.
3. False start: rx low for 1 cycle (shorter than CLKS_PER_BIT/2) -> returns to IDLE, no shift_en, no rx_done.
4. Framing error: send 0x3C with stop bit 0, rx held low for 3 bit times -> 8 shift_en pulses, frame_err pulse, busy stays high until rx returns to 1, no rx_done.
5. Back-to-back: 0x00 then 0xFF with no idle gap -> two rx_done pulses exactly 10 bit periods apart, 16 total shift_en pulses.
6. With UART_RX_PARITY_EN, PARITY_ODD=0: send 0x07 with parity bit 1 -> rx_done and no parity_err; send 0x07 with parity bit 0 -> rx_done and parity_err in the same cycle.
